alu_sequencer: RTL and testbench

//  Multi-pass controller between the instruction decoder and the ALU datapath. Accepts one op per

---
 rtl/alu_sequencer_pkg.sv | 68 ++++++
 rtl/alu_sequencer_bcd_fix.sv | 43 ++++
 rtl/alu_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared constants, types and the first-pass decode for alu_sequencer.
// ALU function encodings are one-hot; ALU_NOP drives no function for undefined opcodes.
package alu_sequencer_pkg;

  localparam int REG_WIDTH = 8;
  localparam int OPP_WIDTH = 5;
  localparam int MSB       = REG_WIDTH - 1;

  localparam logic [OPP_WIDTH-1:0] ALU_NOP = 5'b00000;
  localparam logic [OPP_WIDTH-1:0] ALU_SUM = 5'b00001;
  localparam logic [OPP_WIDTH-1:0] ALU_AND = 5'b00010;
  localparam logic [OPP_WIDTH-1:0] ALU_OR  = 5'b00100;
  localparam logic [OPP_WIDTH-1:0] ALU_XOR = 5'b01000;
  localparam logic [OPP_WIDTH-1:0] ALU_SR  = 5'b10000;

  localparam logic [3:0] CTL_ADC = 4'd0;
  localparam logic [3:0] CTL_SBC = 4'd1;
  localparam logic [3:0] CTL_CMP = 4'd2;
  localparam logic [3:0] CTL_AND = 4'd3;
  localparam logic [3:0] CTL_ORA = 4'd4;
  localparam logic [3:0] CTL_EOR = 4'd5;
  localparam logic [3:0] CTL_ASL = 4'd6;
  localparam logic [3:0] CTL_ROL = 4'd7;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_D = 3;
  localparam int P_V = 6;
  localparam int P_N = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SETUP = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [OPP_WIDTH-1:0] func;
    logic [REG_WIDTH-1:0] a;
    logic [REG_WIDTH-1:0] b;
    logic                 cin;
  } alu_pass_t;

  // ALU drive for the first (often only) pass of an opcode.
  function automatic alu_pass_t first_pass(input logic [3:0]           op,
                                           input logic [REG_WIDTH-1:0] a,
                                           input logic [REG_WIDTH-1:0] b,
                                           input logic                 c);
    alu_pass_t p;
    p.func = ALU_NOP;
    p.a    = a;
    p.b    = '0;
    p.cin  = 1'b0;
    case (op)
      CTL_ADC: begin p.func = ALU_SUM; p.b = b;  p.cin = c;    end
      CTL_SBC: begin p.func = ALU_SUM; p.b = ~b; p.cin = c;    end
      CTL_CMP: begin p.func = ALU_SUM; p.b = ~b; p.cin = 1'b1; end
      CTL_AND: begin p.func = ALU_AND; p.b = b; end
      CTL_ORA: begin p.func = ALU_OR;  p.b = b; end
      CTL_EOR: begin p.func = ALU_XOR; p.b = b; end
      CTL_ASL, CTL_ROL: begin p.func = ALU_SR; p.b = REG_WIDTH'(1); end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/alu_sequencer_bcd_fix.sv
// Decimal-mode adjust for ADC/SBC: derives the second-pass addend and the ADC high-digit carry.
// Only instantiated when ALU_DECIMAL_EN is defined.
module alu_bcd_fix
  import alu_sequencer_pkg::*;
(
  input  logic [3:0]           a_lo_i,
  input  logic [3:0]           b_lo_i,
  input  logic                 c_i,
  input  logic                 sub_i,
  input  logic [REG_WIDTH-1:0] sum_i,
  input  logic                 carry_i,
  output logic [REG_WIDTH-1:0] adj_o,
  output logic                 hi_o
);

  logic [4:0]           lo_add;
  logic [4:0]           lo_sub;
  logic                 lo;
  logic                 hi;
  logic [REG_WIDTH-1:0] lo_fixed;

  always_comb begin
    lo_add   = {1'b0, a_lo_i} + {1'b0, b_lo_i} + {4'b0, c_i};
    lo_sub   = {1'b0, a_lo_i} + {1'b0, ~b_lo_i} + {4'b0, c_i};
    lo       = 1'b0;
    hi       = 1'b0;
    lo_fixed = sum_i;
    adj_o    = '0;
    hi_o     = 1'b0;
    if (sub_i) begin
      // Borrows are undone by adding -6 per digit: 0xFA low, 0xA0 high.
      if (!lo_sub[4]) adj_o = 8'hFA;
      if (!carry_i)   adj_o = adj_o + 8'hA0;
    end else begin
      lo       = lo_add > 5'd9;
      lo_fixed = sum_i + (lo ? 8'h06 : 8'h00);
      hi       = ({carry_i, sum_i} > 9'h099) || (lo_fixed[7:4] > 4'd9);
      adj_o    = {(hi ? 4'h6 : 4'h0), (lo ? 4'h6 : 4'h0)};
      hi_o     = hi;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-pass sequencer driving an external ALU; returns result and N/V/Z/C status.
// Optional BCD second pass for ADC/SBC is enabled by defining ALU_DECIMAL_EN.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int ALU_LATENCY = 1
)
(
  input  logic                 phi1,
  input  logic                 reset_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready is high only in IDLE; rsp_valid holds with data until rsp_ready.
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [REG_WIDTH-1:0] req_a,
  input  logic [REG_WIDTH-1:0] req_b,
  input  logic [REG_WIDTH-1:0] req_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [REG_WIDTH-1:0] rsp_data,
  output logic [REG_WIDTH-1:0] rsp_p,
  output logic [OPP_WIDTH-1:0] alu_func,
  output logic [REG_WIDTH-1:0] alu_a,
  output logic [REG_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  input  logic [REG_WIDTH-1:0] alu_dout,
  input  logic                 alu_carry_out,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);

  seq_state_e           state_q, state_d;
  logic                 pass_q, pass_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [REG_WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic [REG_WIDTH-1:0] r1_q, r1_d;
  logic                 c1_q, c1_d, v1_q, v1_d;
  logic [OPP_WIDTH-1:0] alu_func_q, alu_func_d;
  logic [REG_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                 alu_cin_q, alu_cin_d;
  logic [REG_WIDTH-1:0] rsp_data_q, rsp_data_d, rsp_p_q, rsp_p_d;

  alu_pass_t            setup1, setup2;
  logic [REG_WIDTH-1:0] dec_adj;
  logic                 dec_hi, dec_en;
  logic                 two_pass, v_now, res_zero, fin_c, fin_v;
  logic [REG_WIDTH-1:0] fin_data, fin_p;

`ifdef ALU_DECIMAL_EN
  alu_bcd_fix u_bcd_fix (
    .a_lo_i  (a_q[3:0]),
    .b_lo_i  (b_q[3:0]),
    .c_i     (p_q[P_C]),
    .sub_i   (op_q == CTL_SBC),
    .sum_i   (r1_q),
    .carry_i (c1_q),
    .adj_o   (dec_adj),
    .hi_o    (dec_hi)
  );
  assign dec_en = p_q[P_D] && ((op_q == CTL_ADC) || (op_q == CTL_SBC));
`else
  assign dec_adj = '0;
  assign dec_hi  = 1'b0;
  assign dec_en  = 1'b0;
`endif

  assign two_pass = (op_q == CTL_ROL) || dec_en;
  assign setup1   = first_pass(req_op, req_a, req_b, req_p[P_C]);
  // Overflow uses the operand actually fed to the adder, so SBC sees ~b here.
  assign v_now    = (a_q[MSB] == alu_b_q[MSB]) && (alu_dout[MSB] != a_q[MSB]);
  assign res_zero = (alu_dout == '0);

  always_comb begin
    setup2.func = ALU_OR;
    setup2.a    = r1_q;
    setup2.b    = {{(REG_WIDTH-1){1'b0}}, p_q[P_C]};
    setup2.cin  = 1'b0;
    if (dec_en) begin
      setup2.func = ALU_SUM;
      setup2.b    = dec_adj;
    end
  end

  always_comb begin
    fin_data = alu_dout;
    fin_p    = p_q;
    fin_c    = pass_q ? (c1_q | dec_hi) : alu_carry_out;
    fin_v    = pass_q ? v1_q : v_now;
    case (op_q)
      CTL_ADC, CTL_SBC: begin
        fin_p[P_N] = alu_dout[MSB];
        fin_p[P_Z] = res_zero;
        fin_p[P_C] = fin_c;
        fin_p[P_V] = fin_v;
      end
      CTL_CMP: begin
        fin_data   = a_q;
        fin_p[P_N] = alu_dout[MSB];
        fin_p[P_Z] = res_zero;
        fin_p[P_C] = alu_carry_out;
      end
      CTL_AND, CTL_ORA, CTL_EOR: begin
        fin_p[P_N] = alu_dout[MSB];
        fin_p[P_Z] = res_zero;
      end
      CTL_ASL, CTL_ROL: begin
        fin_p[P_N] = alu_dout[MSB];
        fin_p[P_Z] = res_zero;
        fin_p[P_C] = a_q[MSB];
      end
      default: fin_data = a_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    r1_d       = r1_q;
    c1_d       = c1_q;
    v1_d       = v1_q;
    alu_func_d = alu_func_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cin_d  = alu_cin_q;
    rsp_data_d = rsp_data_q;
    rsp_p_d    = rsp_p_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          a_d        = req_a;
          b_d        = req_b;
          p_d        = req_p;
          pass_d     = 1'b0;
          cnt_d      = CNT_LOAD;
          alu_func_d = setup1.func;
          alu_a_d    = setup1.a;
          alu_b_d    = setup1.b;
          alu_cin_d  = setup1.cin;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!pass_q && two_pass) begin
          r1_d    = alu_dout;
          c1_d    = alu_carry_out;
          v1_d    = v_now;
          state_d = ST_SETUP;
        end else begin
          rsp_data_d = fin_data;
          rsp_p_d    = fin_p;
          state_d    = ST_RESP;
        end
      end
      ST_SETUP: begin
        pass_d     = 1'b1;
        cnt_d      = CNT_LOAD;
        alu_func_d = setup2.func;
        alu_a_d    = setup2.a;
        alu_b_d    = setup2.b;
        alu_cin_d  = setup2.cin;
        state_d    = ST_EXEC;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pass_q     <= 1'b0;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      r1_q       <= '0;
      c1_q       <= 1'b0;
      v1_q       <= 1'b0;
      alu_func_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_p_q    <= '0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p_q        <= p_d;
      r1_q       <= r1_d;
      c1_q       <= c1_d;
      v1_q       <= v1_d;
      alu_func_q <= alu_func_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cin_q  <= alu_cin_d;
      rsp_data_q <= rsp_data_d;
      rsp_p_q    <= rsp_p_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_data     = rsp_data_q;
  assign rsp_p        = rsp_p_q;
  assign alu_func     = alu_func_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_carry_in = alu_cin_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a combinational ALU model (latency 1).
// Decimal expectations switch with ALU_DECIMAL_EN.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int L = 1;

  logic       phi1, reset_n;
  logic       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0] req_op;
  logic [7:0] req_a, req_b, req_p, rsp_data, rsp_p;
  logic [4:0] alu_func;
  logic [7:0] alu_a, alu_b, alu_dout;
  logic       alu_carry_in, alu_carry_out;
  logic [1:0] dbg_state;
  logic [8:0] sh;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a, b, p, exp_d, exp_p;
    int         exp_lat;
  } vec_t;
  vec_t vq[$];

  alu_sequencer #(.ALU_LATENCY(L)) dut (
    .phi1(phi1), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_p(req_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_p(rsp_p),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_dout(alu_dout), .alu_carry_out(alu_carry_out), .dbg_state(dbg_state)
  );

  // clock / reset
  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // external ALU model
  always_comb begin
    alu_dout      = 8'h00;
    alu_carry_out = 1'b0;
    sh            = 9'h000;
    case (alu_func)
      ALU_SUM: {alu_carry_out, alu_dout} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
      ALU_AND: alu_dout = alu_a & alu_b;
      ALU_OR:  alu_dout = alu_a | alu_b;
      ALU_XOR: alu_dout = alu_a ^ alu_b;
      ALU_SR: begin
        sh            = {1'b0, alu_a} << alu_b[2:0];
        alu_dout      = sh[7:0];
        alu_carry_out = sh[8];
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] p, input logic [7:0] d,
                         input logic [7:0] ep, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.p = p;
    v.exp_d = d; v.exp_p = ep; v.exp_lat = lat;
    vq.push_back(v);
  endtask

  // driver tasks
  task automatic drive_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] p);
    @(negedge phi1);
    req_op = op; req_a = a; req_b = b; req_p = p; req_valid = 1'b1;
    @(posedge phi1);
    #1;
    req_valid = 1'b0;
    req_op = 4'($urandom_range(0, 15));
    req_a  = 8'($urandom_range(0, 255));
    req_b  = 8'($urandom_range(0, 255));
    req_p  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge phi1);
      #1;
      lat++;
    end
  endtask

  task automatic release_rsp(input string name);
    @(negedge phi1);
    rsp_ready = 1'b1;
    @(posedge phi1);
    #1;
    rsp_ready = 1'b0;
    check({name, "_back_idle"}, {req_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    int         lat;
    int         seen;
    logic [15:0] e;

    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_p = '0;

    // binary vectors: name op a b p -> data p latency
    add_vec("adc_50_50",   CTL_ADC, 8'h50, 8'h50, 8'h30, 8'hA0, 8'hF0, L);
    add_vec("sbc_00_01",   CTL_SBC, 8'h00, 8'h01, 8'h31, 8'hFF, 8'hB0, L);
    add_vec("cmp_40_40",   CTL_CMP, 8'h40, 8'h40, 8'h70, 8'h40, 8'h73, L);
    add_vec("and_f0_3c",   CTL_AND, 8'hF0, 8'h3C, 8'hB3, 8'h30, 8'h31, L);
    add_vec("ora_zero",    CTL_ORA, 8'h00, 8'h00, 8'h80, 8'h00, 8'h02, L);
    add_vec("eor_ff_0f",   CTL_EOR, 8'hFF, 8'h0F, 8'h00, 8'hF0, 8'h80, L);
    add_vec("asl_81",      CTL_ASL, 8'h81, 8'h00, 8'h00, 8'h02, 8'h01, L);
    add_vec("asl_80",      CTL_ASL, 8'h80, 8'h00, 8'h00, 8'h00, 8'h03, L);
    add_vec("rol_80_c1",   CTL_ROL, 8'h80, 8'h00, 8'h01, 8'h01, 8'h01, 2*L+1);
    add_vec("rol_40_c0",   CTL_ROL, 8'h40, 8'h00, 8'h00, 8'h80, 8'h80, 2*L+1);
    add_vec("adc_ff_01",   CTL_ADC, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h03, L);
    add_vec("adc_7f_00c1", CTL_ADC, 8'h7F, 8'h00, 8'h01, 8'h80, 8'hC0, L);
    add_vec("sbc_80_01",   CTL_SBC, 8'h80, 8'h01, 8'h01, 8'h7F, 8'h41, L);
    add_vec("undef_op",    4'hF,    8'h5A, 8'h33, 8'hC3, 8'h5A, 8'hC3, L);
`ifdef ALU_DECIMAL_EN
    add_vec("adc_bcd_19_28", CTL_ADC, 8'h19, 8'h28, 8'h08, 8'h47, 8'h08, 2*L+1);
    add_vec("adc_bcd_99_01", CTL_ADC, 8'h99, 8'h01, 8'h08, 8'h00, 8'h0B, 2*L+1);
    add_vec("sbc_bcd_10_01", CTL_SBC, 8'h10, 8'h01, 8'h09, 8'h09, 8'h09, 2*L+1);
`else
    add_vec("adc_dbit_19_28", CTL_ADC, 8'h19, 8'h28, 8'h08, 8'h41, 8'h08, L);
    add_vec("adc_dbit_99_01", CTL_ADC, 8'h99, 8'h01, 8'h08, 8'h9A, 8'h88, L);
    add_vec("sbc_dbit_10_01", CTL_SBC, 8'h10, 8'h01, 8'h09, 8'h0F, 8'h09, L);
`endif

    // reset state
    repeat (2) @(posedge phi1);
    #1;
    check("rst_ready_valid", {req_ready, rsp_valid}, 2'b10);
    check("rst_rsp", {rsp_data, rsp_p}, 16'h0000);
    check("rst_alu", {alu_func, alu_a, alu_b, alu_carry_in}, 22'h0);
    check("rst_state", dbg_state, 2'd0);
    @(negedge phi1);
    reset_n = 1'b1;

    // table-driven vectors
    foreach (vq[i]) begin
      @(negedge phi1);
      check({vq[i].name, "_ready"}, req_ready, 1'b1);
      exp_q.push_back({vq[i].exp_d, vq[i].exp_p});
      drive_req(vq[i].op, vq[i].a, vq[i].b, vq[i].p);
      wait_rsp(lat);
      check({vq[i].name, "_lat"}, lat, vq[i].exp_lat);
      e = exp_q.pop_front();
      check({vq[i].name, "_data"}, rsp_data, e[15:8]);
      check({vq[i].name, "_p"}, rsp_p, e[7:0]);
      release_rsp(vq[i].name);
    end

    // ROL pass sequence on the ALU drive
    drive_req(CTL_ROL, 8'h80, 8'h55, 8'h01);
    check("rol_pass1_drive", {alu_func, alu_a, alu_b}, {ALU_SR, 8'h80, 8'h01});
    @(posedge phi1); #1;
    check("rol_setup_no_rsp", rsp_valid, 1'b0);
    @(posedge phi1); #1;
    check("rol_pass2_drive", {alu_func, alu_a, alu_b}, {ALU_OR, 8'h00, 8'h01});
    @(posedge phi1); #1;
    check("rol_seq_rsp", {rsp_valid, rsp_data, rsp_p}, {1'b1, 8'h01, 8'h01});
    release_rsp("rol_seq");

    // backpressure: response frozen, new requests ignored
    drive_req(CTL_ADC, 8'h50, 8'h50, 8'h30);
    wait_rsp(lat);
    check("bp_lat", lat, L);
    for (int k = 0; k < 5; k++) begin
      @(negedge phi1);
      req_valid = 1'b1; req_op = CTL_AND; req_a = 8'($urandom_range(0, 255));
      @(posedge phi1); #1;
      check("bp_hold", {rsp_valid, req_ready, rsp_data, rsp_p}, {1'b1, 1'b0, 8'hA0, 8'hF0});
    end
    @(negedge phi1);
    rsp_ready = 1'b1;
    @(posedge phi1); #1;
    rsp_ready = 1'b0;
    check("bp_no_same_cycle_accept", {req_ready, rsp_valid, dbg_state}, {1'b1, 1'b0, 2'd0});
    @(negedge phi1);
    req_valid = 1'b0;
    @(posedge phi1); #1;
    check("bp_still_idle", req_ready, 1'b1);

    // reset during EXEC
    drive_req(CTL_ADC, 8'h50, 8'h50, 8'h30);
    check("mid_rst_in_exec", dbg_state, 2'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {req_ready, rsp_valid, rsp_data, rsp_p}, {1'b1, 1'b0, 16'h0000});
    check("mid_rst_alu", {alu_func, alu_a, alu_b, alu_carry_in}, 22'h0);
    @(negedge phi1);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge phi1); #1;
      if (rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", seen, 0);
    check("mid_rst_idle", req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
